mini_alu_v2: RTL and testbench

MINI_ALU_V2 -- requirements
Module: mini_alu_v2

---
 rtl/mini_alu_pkg.sv | 33 +++
 rtl/mini_alu_regfile.sv | 28 ++
 rtl/mini_alu_v2.sv | 155 +++++++++++++++
 tb/tb_mini_alu_v2.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mini_alu_pkg.sv
// Shared definitions for the mini ALU: opcode encoding, instruction field
// slots and the multiplier sequencer states.
package mini_alu_pkg;

   localparam int OP_WIDTH = 4;

   // An instruction is {op, dst, src1, src0}; each slot is ADDR_WIDTH wide,
   // so a field's LSB is its slot number times ADDR_WIDTH.
   localparam int SRC0_SLOT = 0;
   localparam int SRC1_SLOT = 1;
   localparam int DST_SLOT  = 2;
   localparam int OP_SLOT   = 3;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_NOP  = 4'd0,
      OP_STO  = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_BLE  = 4'd4,
      OP_JMP  = 4'd5,
      OP_LED  = 4'd6,
      OP_MUL  = 4'd7,
      OP_SMUL = 4'd8,
      OP_HALT = 4'd9
   } opcode_t;

   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_RUN,
      MUL_WRHI
   } mulState_t;

endpackage

// File: rtl/mini_alu_regfile.sv
// Register file: one synchronous write port, two asynchronous read ports.
// Contents are deliberately not reset.
module mini_alu_regfile #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
)(
   input  logic                  clock,
   input  logic                  writeEnable,
   input  logic [ADDR_WIDTH-1:0] writeAddr,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic [ADDR_WIDTH-1:0] readAddrA,
   output logic [DATA_WIDTH-1:0] readDataA,
   input  logic [ADDR_WIDTH-1:0] readAddrB,
   output logic [DATA_WIDTH-1:0] readDataB
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clock) begin
      if (writeEnable) begin
         mem[writeAddr] <= writeData;
      end
   end

   assign readDataA = mem[readAddrA];
   assign readDataB = mem[readAddrB];

endmodule

// File: rtl/mini_alu_v2.sv
// Two-stage (fetch/execute) mini ALU with branch, LED latch, HALT and a
// sequential shift-add multiplier that stalls the pipeline while it runs.
module mini_alu_v2
   import mini_alu_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int IP_WIDTH   = 16,
   parameter int LED_WIDTH  = 8
)(
   input  logic                             Clock,
   input  logic                             Reset,
   output logic [IP_WIDTH-1:0]              oIP,
   input  logic [OP_WIDTH+3*ADDR_WIDTH-1:0] iInstruction,
   output logic [LED_WIDTH-1:0]             oLed,
   output logic                             oBusy,
   output logic                             oHalted
);

   localparam int INSTR_W = OP_WIDTH + 3*ADDR_WIDTH;
   localparam int CNT_W   = $clog2(DATA_WIDTH) + 1;

   logic [INSTR_W-1:0]      fetchReg;
   logic [IP_WIDTH-1:0]     ipReg;
   opcode_t                 op;
   logic [ADDR_WIDTH-1:0]   dst, src1, src0;
   logic [DATA_WIDTH-1:0]   rdA, rdB, imm, magA, magB;
   logic                    executeEn, isMul, mulStart, branchTaken, fetchHold;

   mulState_t               mulState;
   logic [CNT_W-1:0]        stepCount;
   logic                    lastStep, negate;
   logic [DATA_WIDTH-1:0]   mcand;
   logic [2*DATA_WIDTH-1:0] acc, accStep, prodStep;
   logic [DATA_WIDTH:0]     partial;

   logic                    wrEn;
   logic [ADDR_WIDTH-1:0]   wrAddr;
   logic [DATA_WIDTH-1:0]   wrData;

   assign op   = opcode_t'(fetchReg[OP_SLOT*ADDR_WIDTH +: OP_WIDTH]);
   assign dst  = fetchReg[DST_SLOT*ADDR_WIDTH  +: ADDR_WIDTH];
   assign src1 = fetchReg[SRC1_SLOT*ADDR_WIDTH +: ADDR_WIDTH];
   assign src0 = fetchReg[SRC0_SLOT*ADDR_WIDTH +: ADDR_WIDTH];
   assign imm  = DATA_WIDTH'({src1, src0});

   mini_alu_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) regFile (
      .clock       (Clock),
      .writeEnable (wrEn),
      .writeAddr   (wrAddr),
      .writeData   (wrData),
      .readAddrA   (src1),
      .readDataA   (rdA),
      .readAddrB   (src0),
      .readDataB   (rdB)
   );

   // Ordinary instructions only execute when the multiplier is idle and the core is running.
   assign executeEn   = (mulState == MUL_IDLE) && !oHalted;
   assign isMul       = (op == OP_MUL) || (op == OP_SMUL);
   assign mulStart    = executeEn && isMul;
   assign oBusy       = mulStart || (mulState != MUL_IDLE);
   assign branchTaken = executeEn && ((op == OP_JMP) || ((op == OP_BLE) && (rdA <= rdB)));
   assign oIP         = branchTaken ? IP_WIDTH'(dst) : ipReg;

   // The multiply stays in fetch until its WRHI cycle so the next word is fetched as it retires.
   assign fetchHold = oHalted || (executeEn && op == OP_HALT) || (oBusy && mulState != MUL_WRHI);

   assign magA = ((op == OP_SMUL) && rdA[DATA_WIDTH-1]) ? -rdA : rdA;
   assign magB = ((op == OP_SMUL) && rdB[DATA_WIDTH-1]) ? -rdB : rdB;

   assign partial  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
   assign accStep  = {partial, acc[DATA_WIDTH-1:1]};
   assign prodStep = negate ? -accStep : accStep;
   assign lastStep = (stepCount == CNT_W'(DATA_WIDTH - 1));

   always_comb begin
      wrEn   = 1'b0;
      wrAddr = dst;
      wrData = imm;
      if (mulState == MUL_RUN) begin
         wrEn   = lastStep;
         wrData = prodStep[DATA_WIDTH-1:0];
      end else if (mulState == MUL_WRHI) begin
         wrEn   = 1'b1;
         wrAddr = dst + ADDR_WIDTH'(1);
         wrData = acc[2*DATA_WIDTH-1:DATA_WIDTH];
      end else if (executeEn) begin
         unique case (op)
            OP_STO:  wrEn = 1'b1;
            OP_ADD:  begin wrEn = 1'b1; wrData = rdA + rdB; end
            OP_SUB:  begin wrEn = 1'b1; wrData = rdA - rdB; end
            default: wrEn = 1'b0;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         ipReg    <= '0;
         fetchReg <= '0;
         oLed     <= '0;
         oHalted  <= 1'b0;
      end else begin
         if (!fetchHold) begin
            fetchReg <= iInstruction;
            ipReg    <= oIP + IP_WIDTH'(1);
         end
         if (executeEn && op == OP_LED) begin
            oLed <= rdA[LED_WIDTH-1:0];
         end
         if (executeEn && op == OP_HALT) begin
            oHalted <= 1'b1;
         end
      end
   end

   // Right-shifting multiplier: multiplier magnitude starts in the low half of acc.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         mulState  <= MUL_IDLE;
         stepCount <= '0;
         mcand     <= '0;
         acc       <= '0;
         negate    <= 1'b0;
      end else begin
         unique case (mulState)
            MUL_IDLE: begin
               if (mulStart) begin
                  mcand     <= magA;
                  acc       <= {{DATA_WIDTH{1'b0}}, magB};
                  negate    <= (op == OP_SMUL) && (rdA[DATA_WIDTH-1] ^ rdB[DATA_WIDTH-1]);
                  stepCount <= '0;
                  mulState  <= MUL_RUN;
               end
            end
            MUL_RUN: begin
               stepCount <= stepCount + CNT_W'(1);
               if (lastStep) begin
                  acc      <= prodStep;
                  mulState <= MUL_WRHI;
               end else begin
                  acc <= accStep;
               end
            end
            MUL_WRHI: mulState <= MUL_IDLE;
            default:  mulState <= MUL_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mini_alu_v2.sv
// Directed bench for mini_alu_v2: small programs in a behavioural ROM,
// hand-computed expectations checked with immediate assertions.
module tb_mini_alu_v2;

   localparam int DW  = 16;
   localparam int AW  = 8;
   localparam int IPW = 16;
   localparam int LW  = 8;
   localparam int IW  = 4 + 3*AW;

   logic           Clock = 1'b0;
   logic           Reset = 1'b0;
   logic [IPW-1:0] oIP;
   logic [IW-1:0]  iInstruction;
   logic [LW-1:0]  oLed;
   logic           oBusy;
   logic           oHalted;

   logic [IW-1:0]  rom [256];
   int             checks = 0;
   int             errors = 0;
   int             busyCycles;
   logic           ipStable;

   assign iInstruction = rom[oIP[7:0]];

   mini_alu_v2 #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .IP_WIDTH   (IPW),
      .LED_WIDTH  (LW)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .oIP          (oIP),
      .iInstruction (iInstruction),
      .oLed         (oLed),
      .oBusy        (oBusy),
      .oHalted      (oHalted)
   );

   always #5 Clock = ~Clock;

   function automatic logic [IW-1:0] enc(input logic [3:0] op, input logic [7:0] d,
                                         input logic [7:0] s1, input logic [7:0] s0);
      return {op, d, s1, s0};
   endfunction

   function automatic logic [IW-1:0] sto(input logic [7:0] d, input logic [15:0] value);
      return enc(4'd1, d, value[15:8], value[7:0]);
   endfunction

   task automatic clearRom();
      for (int i = 0; i < 256; i++) rom[i] = '0;
   endtask

   task automatic applyStimulus(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Arithmetic chain into the LED latch, plus reset values.
      clearRom();
      rom[0] = sto(8'd1, 16'h0005);
      rom[1] = sto(8'd2, 16'h0007);
      rom[2] = enc(4'd2, 8'd3, 8'd2, 8'd1);
      rom[3] = enc(4'd6, 8'd0, 8'd3, 8'd0);
      Reset = 1'b0;
      applyStimulus(2);
      checkOutput("rstIP",     32'(oIP),     32'h0);
      checkOutput("rstBusy",   32'(oBusy),   32'h0);
      checkOutput("rstHalted", 32'(oHalted), 32'h0);
      checkOutput("rstLed",    32'(oLed),    32'h0);
      Reset = 1'b1;
      applyStimulus(4);
      checkOutput("ledIPNoStall", 32'(oIP),   32'h4);
      checkOutput("ledBefore",    32'(oLed),  32'h0);
      checkOutput("ledBusy",      32'(oBusy), 32'h0);
      applyStimulus(1);
      checkOutput("ledValue", 32'(oLed), 32'h0C);
      checkOutput("addR3",    32'(dut.regFile.mem[3]), 32'h000C);

      // JMP, taken BLE, not-taken BLE; wrong-path words must never execute.
      clearRom();
      rom[8'h00] = sto(8'd1, 16'h0004);
      rom[8'h01] = sto(8'd2, 16'h0004);
      rom[8'h02] = sto(8'd6, 16'h0011);
      rom[8'h03] = enc(4'd5, 8'h0A, 8'd0, 8'd0);
      rom[8'h04] = sto(8'd6, 16'h0099);
      rom[8'h0B] = enc(4'd4, 8'h20, 8'd1, 8'd2);
      rom[8'h0C] = sto(8'd6, 16'h0066);
      rom[8'h20] = sto(8'd1, 16'h0005);
      rom[8'h21] = enc(4'd4, 8'h40, 8'd1, 8'd2);
      rom[8'h22] = sto(8'd6, 16'h0042);
      Reset = 1'b0;
      applyStimulus(2);
      Reset = 1'b1;
      applyStimulus(4);
      checkOutput("jmpTarget", 32'(oIP), 32'h0A);
      applyStimulus(1);
      checkOutput("jmpNext", 32'(oIP), 32'h0B);
      applyStimulus(1);
      checkOutput("bleTaken", 32'(oIP), 32'h20);
      applyStimulus(1);
      checkOutput("bleTarget", 32'(oIP), 32'h21);
      checkOutput("noDelaySlot", 32'(dut.regFile.mem[6]), 32'h0011);
      applyStimulus(1);
      checkOutput("bleNotTaken", 32'(oIP), 32'h22);
      applyStimulus(2);
      checkOutput("fallThrough", 32'(dut.regFile.mem[6]), 32'h0042);

      // Unsigned multiply: 0x1234 * 0x0100 = 0x00123400.
      clearRom();
      rom[0] = sto(8'd1, 16'h1234);
      rom[1] = sto(8'd2, 16'h0100);
      rom[2] = enc(4'd7, 8'd4, 8'd1, 8'd2);
      rom[3] = sto(8'd6, 16'h00AB);
      Reset = 1'b0;
      applyStimulus(2);
      Reset = 1'b1;
      applyStimulus(3);
      checkOutput("mulBusyRise", 32'(oBusy), 32'h1);
      checkOutput("mulIP",       32'(oIP),   32'h3);
      busyCycles = 0;
      ipStable   = 1'b1;
      for (int i = 0; i < 40 && oBusy; i++) begin
         busyCycles++;
         if (oIP !== 16'h0003) ipStable = 1'b0;
         applyStimulus(1);
      end
      checkOutput("mulBusyCycles", 32'(busyCycles), 32'd18);
      checkOutput("mulIPFrozen",   32'(ipStable),   32'h1);
      checkOutput("mulResumeIP",   32'(oIP),        32'h4);
      checkOutput("mulLo", 32'(dut.regFile.mem[4]), 32'h3400);
      checkOutput("mulHi", 32'(dut.regFile.mem[5]), 32'h0012);
      applyStimulus(1);
      checkOutput("afterMul", 32'(dut.regFile.mem[6]), 32'h00AB);

      // Signed multiply: -3 * 5 = -15, high half lands in R[0] after wrap.
      clearRom();
      rom[0] = sto(8'd1, 16'hFFFD);
      rom[1] = sto(8'd2, 16'h0005);
      rom[2] = enc(4'd8, 8'hFF, 8'd1, 8'd2);
      Reset = 1'b0;
      applyStimulus(2);
      Reset = 1'b1;
      applyStimulus(22);
      checkOutput("smulLo",   32'(dut.regFile.mem[8'hFF]), 32'hFFF1);
      checkOutput("smulHi",   32'(dut.regFile.mem[8'h00]), 32'hFFFF);
      checkOutput("smulIdle", 32'(oBusy), 32'h0);

      // Reset in the middle of a multiply must abort without writing.
      clearRom();
      rom[0] = sto(8'd4, 16'hAAAA);
      rom[1] = sto(8'd5, 16'h5555);
      rom[2] = sto(8'd1, 16'h1234);
      rom[3] = sto(8'd2, 16'h0100);
      rom[4] = enc(4'd7, 8'd4, 8'd1, 8'd2);
      Reset = 1'b0;
      applyStimulus(2);
      Reset = 1'b1;
      applyStimulus(5);
      checkOutput("abortBusyStart", 32'(oBusy), 32'h1);
      applyStimulus(5);
      checkOutput("abortBusyMid", 32'(oBusy), 32'h1);
      Reset = 1'b0;
      #1;
      checkOutput("abortBusy", 32'(oBusy), 32'h0);
      checkOutput("abortIP",   32'(oIP),   32'h0);
      clearRom();
      applyStimulus(3);
      checkOutput("abortR4", 32'(dut.regFile.mem[4]), 32'hAAAA);
      checkOutput("abortR5", 32'(dut.regFile.mem[5]), 32'h5555);
      Reset = 1'b1;
      applyStimulus(3);
      checkOutput("abortR4Later", 32'(dut.regFile.mem[4]), 32'hAAAA);
      checkOutput("abortR5Later", 32'(dut.regFile.mem[5]), 32'h5555);

      // HALT at address 6 freezes the core.
      clearRom();
      rom[0] = sto(8'd3, 16'h0033);
      rom[6] = enc(4'd9, 8'd0, 8'd0, 8'd0);
      rom[7] = sto(8'd3, 16'h0077);
      rom[8] = sto(8'd3, 16'h0088);
      Reset = 1'b0;
      applyStimulus(2);
      Reset = 1'b1;
      applyStimulus(7);
      checkOutput("haltPending", 32'(oHalted), 32'h0);
      checkOutput("haltExecIP",  32'(oIP),     32'h7);
      applyStimulus(1);
      checkOutput("haltSet", 32'(oHalted), 32'h1);
      checkOutput("haltIP",  32'(oIP),     32'h7);
      ipStable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1);
         if (oIP !== 16'h0007) ipStable = 1'b0;
      end
      checkOutput("haltIPFrozen", 32'(ipStable), 32'h1);
      checkOutput("haltSticky",   32'(oHalted),  32'h1);
      checkOutput("haltNoWrite",  32'(dut.regFile.mem[3]), 32'h0033);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
